// File: rtl/sonar_medidor_hcsr04_pkg.sv
// Shared definitions for the HC-SR04 ranging front-end.
// Holds the FSM state codes, which the display side also decodes, and the
// default 50 MHz-derived timing constants. It also provides a saturating
// 3-digit BCD increment helper.
package sonar_medidor_hcsr04_pkg;

  // State codes are fixed because db_estado drives the hexa7seg debug display.
  typedef enum logic [3:0] {
    INICIAL       = 4'h0,
    PREPARA       = 4'h1,
    ENVIA_TRIGGER = 4'h2,
    ESPERA_ECHO   = 4'h3,
    MEDINDO       = 4'h4,
    ARMAZENA      = 4'h5,
    FINAL         = 4'h6,
    ERRO          = 4'hF
  } estado_t;

  // Defaults for a 50 MHz clock.
  localparam int DEF_TRIGGER_CYCLES = 500;        // 10 us
  localparam int DEF_CM_CYCLES      = 2941;       // 58.82 us per cm
  localparam int DEF_ECHO_TIMEOUT   = 2_500_000;  // 50 ms
  localparam int DEF_SYNC_STAGES    = 2;

  localparam int BCD_W = 12;

  // Add one to a 3-digit BCD value. Each digit wraps 9->0 with a carry.
  // The value saturates at 999 rather than rolling over to 000.
  function automatic logic [BCD_W-1:0] bcd_inc_sat(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    if (v != 12'h999) begin
      if (v[3:0] != 4'd9) begin
        r[3:0] = v[3:0] + 4'd1;
      end else begin
        r[3:0] = 4'd0;
        if (v[7:4] != 4'd9) begin
          r[7:4] = v[7:4] + 4'd1;
        end else begin
          r[7:4]  = 4'd0;
          r[11:8] = v[11:8] + 4'd1;  // hundreds cannot be 9 here, 999 excluded above
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sonar_medidor_hcsr04_contador_bcd_3dig.sv
// Three-digit saturating BCD counter used to accumulate whole centimetres.
// Ports: clock, reset (async active-low), zera_i (sync clear, wins over count),
//        conta_i (increment by one, saturating at 999), bcd_o {centenas,dezenas,unidades}.
// Latency: bcd_o reflects zera_i/conta_i one clock after they are sampled.
module sonar_medidor_hcsr04_contador_bcd_3dig
  import sonar_medidor_hcsr04_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             zera_i,
  input  logic             conta_i,
  output logic [BCD_W-1:0] bcd_o
);

  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] bcd_d;

  always_comb begin
    bcd_d = bcd_q;
    if (zera_i) begin
      bcd_d = '0;
    end else if (conta_i) begin
      bcd_d = bcd_inc_sat(bcd_q);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      bcd_q <= '0;
    end else begin
      bcd_q <= bcd_d;
    end
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/sonar_medidor_hcsr04.sv
// HC-SR04 front-end. On a medir request it fires the trigger pulse and times
// the echo, then reports the distance in cm as 3 BCD digits with a one-cycle
// pronto pulse. On a timeout, erro pulses together with pronto instead.
// Ports: clock, reset (async active-low), medir (request pulse, only honoured when idle),
//        echo (raw async sensor input), trigger, medida[11:0] (BCD cm), pronto, erro,
//        db_estado[3:0] (current state code). Every output comes from a register.
module sonar_medidor_hcsr04
  import sonar_medidor_hcsr04_pkg::*;
#(
  parameter int TRIGGER_CYCLES = DEF_TRIGGER_CYCLES,
  parameter int CM_CYCLES      = DEF_CM_CYCLES,
  parameter int ECHO_TIMEOUT   = DEF_ECHO_TIMEOUT,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             medir,
  input  logic             echo,
  output logic             trigger,
  output logic [BCD_W-1:0] medida,
  output logic             pronto,
  output logic             erro,
  output logic [3:0]       db_estado
);

  // The state-time counter serves both the trigger width and the echo timeouts.
  localparam int CNT_MAX = (ECHO_TIMEOUT > TRIGGER_CYCLES) ? ECHO_TIMEOUT : TRIGGER_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TICK_W  = (CM_CYCLES > 2) ? $clog2(CM_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(ECHO_TIMEOUT - 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CM_CYCLES - 1);
  localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(CM_CYCLES / 2);

  estado_t           state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TICK_W-1:0] tick_q, tick_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              echo_s;
  logic              cm_wrap;
  logic [BCD_W-1:0]  bcd_cm;

  logic             trigger_q, trigger_d;
  logic             pronto_q, pronto_d;
  logic             erro_q, erro_d;
  logic [BCD_W-1:0] medida_q, medida_d;

  // ---------------------------------------------------------------------------
  // Echo synchroniser: raw echo is only ever used after the last stage.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], echo};
    end
  end

  assign echo_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= INICIAL;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      INICIAL:       if (medir) state_d = PREPARA;
      PREPARA:       state_d = ENVIA_TRIGGER;
      ENVIA_TRIGGER: if (cnt_q == TRIG_LAST) state_d = ESPERA_ECHO;
      ESPERA_ECHO: begin
        // A level test rather than an edge test, so an echo that is already
        // high on entry starts the measurement on the very next cycle.
        if (echo_s)                state_d = MEDINDO;
        else if (cnt_q == TO_LAST) state_d = ERRO;
      end
      MEDINDO: begin
        if (!echo_s)               state_d = ARMAZENA;
        else if (cnt_q == TO_LAST) state_d = ERRO;
      end
      ARMAZENA:      state_d = FINAL;
      FINAL:         state_d = INICIAL;
      ERRO:          state_d = INICIAL;
      default:       state_d = INICIAL;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: registered outputs
  // pronto/erro are decoded from the next state, so their pulses line up
  // exactly with the FINAL/ERRO cycle. trigger is decoded from the current
  // state, which delays it by one edge: it rises on the second edge after
  // medir is taken and stays high for exactly TRIGGER_CYCLES clocks.
  // ---------------------------------------------------------------------------
  always_comb begin
    trigger_d = (state_q == ENVIA_TRIGGER);
    pronto_d  = (state_d == FINAL) || (state_d == ERRO);
    erro_d    = (state_d == ERRO);
    medida_d  = medida_q;
    if (state_q == ARMAZENA) begin
      // Round half-up on the partial centimetre left in the tick counter.
      medida_d = (tick_q >= TICK_HALF) ? bcd_inc_sat(bcd_cm) : bcd_cm;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      trigger_q <= 1'b0;
      pronto_q  <= 1'b0;
      erro_q    <= 1'b0;
      medida_q  <= '0;
    end else begin
      trigger_q <= trigger_d;
      pronto_q  <= pronto_d;
      erro_q    <= erro_d;
      medida_q  <= medida_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Time spent in the current state. The counter restarts on every state
  // change and is parked at zero while idle.
  // ---------------------------------------------------------------------------
  always_comb begin
    if ((state_d != state_q) || (state_q == INICIAL)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Centimetre tick counter. It only runs while MEDINDO sees echo high. The
  // cycle that moves ESPERA_ECHO to MEDINDO is therefore not counted, and an
  // echo N clocks wide accumulates N-1 ticks.
  // ---------------------------------------------------------------------------
  assign cm_wrap = (state_q == MEDINDO) && echo_s && (tick_q == TICK_LAST);

  always_comb begin
    tick_d = tick_q;
    if (state_q == PREPARA) begin
      tick_d = '0;
    end else if ((state_q == MEDINDO) && echo_s) begin
      tick_d = cm_wrap ? '0 : tick_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  sonar_medidor_hcsr04_contador_bcd_3dig u_contador (
    .clock   (clock),
    .reset   (reset),
    .zera_i  (state_q == PREPARA),
    .conta_i (cm_wrap),
    .bcd_o   (bcd_cm)
  );

  assign trigger   = trigger_q;
  assign pronto    = pronto_q;
  assign erro      = erro_q;
  assign medida    = medida_q;
  assign db_estado = state_q;

endmodule

// File: tb/tb_sonar_medidor_hcsr04.sv
module tb_sonar_medidor_hcsr04;

  localparam int TRIG = 500;
  localparam int CM   = 11;     // odd like 2941: CM/2 = 5
  localparam int TO   = 12000;  // raised so 1000 cm fits inside the timeout

  typedef struct {
    logic [11:0] medida;
    logic        erro;
    logic [3:0]  estado;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        medir = 1'b0;
  logic        echo = 1'b0;
  logic        trigger;
  logic [11:0] medida;
  logic        pronto;
  logic        erro;
  logic [3:0]  db_estado;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  sonar_medidor_hcsr04 #(
    .TRIGGER_CYCLES (TRIG),
    .CM_CYCLES      (CM),
    .ECHO_TIMEOUT   (TO),
    .SYNC_STAGES    (2)
  ) dut (
    .clock     (clk),
    .reset     (reset),
    .medir     (medir),
    .echo      (echo),
    .trigger   (trigger),
    .medida    (medida),
    .pronto    (pronto),
    .erro      (erro),
    .db_estado (db_estado)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Monitor: each pronto pulse pops one expectation and compares the result.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (pronto === 1'b1) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pronto: medida=%h erro=%b estado=%h", medida, erro, db_estado);
      end else begin
        e = sb.pop_front();
        if (medida !== e.medida || erro !== e.erro || db_estado !== e.estado) begin
          miscompares++;
          $display("FAIL result: got medida=%h erro=%b estado=%h expected medida=%h erro=%b estado=%h",
                   medida, erro, db_estado, e.medida, e.erro, e.estado);
        end
      end
    end else if (erro === 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL erro_without_pronto: got erro=1 expected 0");
    end
  end

  // One full measurement. The echo is n clocks wide; n=0 means it never rises.
  // poke pulses medir twice while the echo is high; those pulses must be ignored.
  task automatic measure(input string name, input int n, input logic [11:0] exp_m,
                         input logic exp_e, input logic poke);
    exp_t e;
    int   hi;
    int   w;
    e.medida = exp_m;
    e.erro   = exp_e;
    e.estado = exp_e ? 4'hF : 4'h6;
    sb.push_back(e);

    @(negedge clk); medir = 1'b1;
    @(negedge clk); medir = 1'b0;            // edge E0 sampled medir
    check({name, "_trig_after_e0"}, {31'b0, trigger}, 0);
    @(negedge clk);
    check({name, "_trig_after_e1"}, {31'b0, trigger}, 0);
    @(negedge clk);
    check({name, "_trig_after_e2"}, {31'b0, trigger}, 1);
    hi = 0;
    while (trigger === 1'b1 && hi < 1000) begin
      hi++;
      @(negedge clk);
    end
    check({name, "_trig_width"}, hi, TRIG);

    repeat (10) @(negedge clk);
    if (n > 0) begin
      echo = 1'b1;
      for (int i = 0; i < n; i++) begin
        medir = poke && (i == 30 || i == 60);
        @(negedge clk);
      end
      medir = 1'b0;
      echo  = 1'b0;
    end

    w = 0;
    while (sb.size() != 0 && w < 20000) begin
      w++;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_no_pronto: got no pronto within 20000 cycles expected one", name);
      sb.delete();
    end
    @(negedge clk);
    check({name, "_back_to_idle"}, {28'b0, db_estado}, 0);
    check({name, "_pronto_single"}, {31'b0, pronto}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_trigger", {31'b0, trigger}, 0);
    check("rst_medida", {20'b0, medida}, 12'h000);
    check("rst_pronto", {31'b0, pronto}, 0);
    check("rst_erro", {31'b0, erro}, 0);
    check("rst_estado", {28'b0, db_estado}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // 12 cm exactly, then the rounding boundary either side of half a cm.
    measure("cm12",      12*CM,     12'h012, 1'b0, 1'b0);
    measure("cm12_up",   12*CM + 6, 12'h013, 1'b0, 1'b0);
    measure("cm12_down", 12*CM + 5, 12'h012, 1'b0, 1'b0);
    measure("cm100",     100*CM,    12'h100, 1'b0, 1'b0);
    measure("cm999_sat", 1000*CM,   12'h999, 1'b0, 1'b0);
    // No echo: erro with medida left at its previous value.
    measure("timeout",   0,         12'h999, 1'b1, 1'b0);
    measure("poke",      12*CM,     12'h012, 1'b0, 1'b1);

    // Reset in the middle of MEDINDO.
    @(negedge clk); medir = 1'b1;
    @(negedge clk); medir = 1'b0;
    repeat (TRIG + 20) @(negedge clk);
    echo = 1'b1;
    repeat (50) @(negedge clk);
    check("mid_estado_medindo", {28'b0, db_estado}, 4);
    reset = 1'b0;
    #1;
    check("mid_rst_trigger", {31'b0, trigger}, 0);
    check("mid_rst_medida", {20'b0, medida}, 12'h000);
    check("mid_rst_pronto", {31'b0, pronto}, 0);
    check("mid_rst_estado", {28'b0, db_estado}, 0);
    @(negedge clk);
    echo = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    measure("after_rst", 12*CM + 6, 12'h013, 1'b0, 1'b0);

    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
